// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle arithmetic/logic/shift ops plus iterative
// shift-add multiply and restoring divide, with a registered result/NZCV port.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_oper,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             busy
);

  // Handshake: a request transfers on any edge where in_valid && in_ready;
  // a result transfers on any edge where out_valid && out_ready.

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_ADC  = 4'd1,  OP_SUB  = 4'd2,  OP_SBC = 4'd3;
  localparam logic [3:0] OP_RSB  = 4'd4,  OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_XOR = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8,  OP_LSR  = 4'd9,  OP_ASR  = 4'd10, OP_ROL = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12, OP_MUL  = 4'd13, OP_UDIV = 4'd14, OP_UREM = 4'd15;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;
  logic [1:0]       cv_q;
  logic [WIDTH-1:0] acc_q, x_q, y_q;

  logic accept, is_iter;
  assign accept  = in_valid && in_ready;
  assign is_iter = (in_oper == OP_MUL) || (in_oper == OP_UDIV) || (in_oper == OP_UREM);

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin, add_v;
  logic [WIDTH:0]   sum;

  always_comb begin
    add_a   = in_a;
    add_b   = in_b;
    add_cin = 1'b0;
    case (in_oper)
      OP_ADC: add_cin = in_flags[1];
      OP_SUB: begin add_b = ~in_b; add_cin = 1'b1; end
      OP_SBC: begin add_b = ~in_b; add_cin = in_flags[1]; end
      OP_RSB: begin add_a = in_b; add_b = ~in_a; add_cin = 1'b1; end
      default: ;
    endcase
  end

  assign sum   = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign add_v = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);

  // Extra bit on each linear shift catches the last bit shifted out.
  logic [SHW-1:0]   amt, amt_rol;
  logic [WIDTH:0]   lsl_ext, lsr_ext, asr_ext;
  logic [WIDTH-1:0] ror_res, rol_res;

  assign amt     = in_b[SHW-1:0];
  assign amt_rol = -amt;
  assign lsl_ext = {1'b0, in_a} << amt;
  assign lsr_ext = {in_a, 1'b0} >> amt;
  assign asr_ext = $unsigned($signed({in_a, 1'b0}) >>> amt);
  assign ror_res = WIDTH'({in_a, in_a} >> amt);
  assign rol_res = WIDTH'({in_a, in_a} >> amt_rol);

  logic [WIDTH-1:0] s_res;
  logic             s_c, s_v;
  logic [3:0]       s_flags;

  always_comb begin
    s_res = '0;
    s_c   = in_flags[1];
    s_v   = in_flags[0];
    case (in_oper)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_RSB: begin
        s_res = sum[WIDTH-1:0];
        s_c   = sum[WIDTH];
        s_v   = add_v;
      end
      OP_AND: s_res = in_a & in_b;
      OP_OR:  s_res = in_a | in_b;
      OP_XOR: s_res = in_a ^ in_b;
      OP_LSL: begin s_res = lsl_ext[WIDTH-1:0]; if (amt != '0) s_c = lsl_ext[WIDTH]; end
      OP_LSR: begin s_res = lsr_ext[WIDTH:1];   if (amt != '0) s_c = lsr_ext[0];     end
      OP_ASR: begin s_res = asr_ext[WIDTH:1];   if (amt != '0) s_c = asr_ext[0];     end
      OP_ROL: begin s_res = rol_res;            if (amt != '0) s_c = rol_res[0];     end
      OP_ROR: begin s_res = ror_res;            if (amt != '0) s_c = ror_res[WIDTH-1]; end
      default: ;
    endcase
  end

  assign s_flags = {s_res[WIDTH-1], (s_res == '0), s_c, s_v};

  // ---------------- iterative datapath ----------------
  // MUL: acc=product, x=multiplier (shifts right), y=multiplicand (shifts left).
  // DIV: acc=remainder, x=dividend shifting into quotient, y=divisor.
  logic [WIDTH-1:0] it_acc, it_x, it_y, div_diff, fin_res;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge, fin_v;
  logic [3:0]       fin_flags;

  assign rem_sh   = {acc_q, x_q[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, y_q};
  assign div_diff = rem_sh[WIDTH-1:0] - y_q;

  always_comb begin
    if (op_q == OP_MUL) begin
      it_acc = x_q[0] ? (acc_q + y_q) : acc_q;
      it_x   = x_q >> 1;
      it_y   = y_q << 1;
    end else begin
      it_acc = div_ge ? div_diff : rem_sh[WIDTH-1:0];
      it_x   = {x_q[WIDTH-2:0], div_ge};
      it_y   = y_q;
    end
  end

  // A zero divisor naturally yields all-ones quotient and remainder == a.
  assign fin_res   = (op_q == OP_UDIV) ? it_x : it_acc;
  assign fin_v     = (op_q == OP_MUL) ? cv_q[0] : (y_q == '0);
  assign fin_flags = {fin_res[WIDTH-1], (fin_res == '0), cv_q[1], fin_v};

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    case (state_q)
      S_IDLE: if (in_valid) state_d = is_iter ? S_BUSY : S_DONE;
      S_BUSY: if (cnt_q == '0) state_d = S_DONE;
      S_DONE: begin
        if (in_valid && out_ready) state_d = is_iter ? S_BUSY : S_DONE;
        else if (out_ready)        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      op_q       <= '0;
      cv_q       <= '0;
      acc_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (accept) begin
      op_q <= in_oper;
      cv_q <= in_flags[1:0];
      if (is_iter) begin
        cnt_q <= SHW'(WIDTH - 1);
        acc_q <= '0;
        x_q   <= (in_oper == OP_MUL) ? in_b : in_a;
        y_q   <= (in_oper == OP_MUL) ? in_a : in_b;
      end else begin
        out_result <= s_res;
        out_flags  <= s_flags;
      end
    end else if (state_q == S_BUSY) begin
      acc_q <= it_acc;
      x_q   <= it_x;
      y_q   <= it_y;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        out_result <= fin_res;
        out_flags  <= fin_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32).
module tb_alu_seq;
  localparam int W = 32;

  localparam logic [3:0] ADD = 4'd0, ADC = 4'd1, SUB = 4'd2, SBC = 4'd3, RSB = 4'd4;
  localparam logic [3:0] AND_ = 4'd5, OR_ = 4'd6, XOR_ = 4'd7, LSL = 4'd8, LSR = 4'd9;
  localparam logic [3:0] ASR = 4'd10, ROL = 4'd11, ROR = 4'd12, MUL = 4'd13;
  localparam logic [3:0] UDIV = 4'd14, UREM = 4'd15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_oper = '0;
  logic [W-1:0] in_a = '0, in_b = '0;
  logic [3:0]   in_flags = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic [3:0]   out_flags;
  logic         busy;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   fl;
    logic [W-1:0] res;
    logic [3:0]   ofl;
  } vec_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_oper(in_oper),
    .in_a(in_a), .in_b(in_b), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] fl);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1; in_oper = op; in_a = a; in_b = b; in_flags = fl;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: captured values must be used.
    in_valid = 1'b0; in_oper = 4'h0; in_a = 32'hdeadbeef; in_b = '0; in_flags = 4'hf;
  endtask

  task automatic wait_result(output int lat, output int busy_n, output int rdy_n);
    lat = 1; busy_n = 0; rdy_n = 0;
    while (!out_valid && lat < 100) begin
      if (busy) busy_n++;
      if (in_ready) rdy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (out_result !== '0) begin failures++; $display("FAIL reset out_result: got %h want 0", out_result); end
    checks++; if (out_flags !== 4'h0) begin failures++; $display("FAIL reset out_flags: got %b want 0000", out_flags); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_ops();
    vec_t v[16];
    v[0]  = '{ADD,  32'h7FFFFFFF, 32'h00000001, 4'b0000, 32'h80000000, 4'b1001};
    v[1]  = '{SBC,  32'h00000005, 32'h00000005, 4'b0000, 32'hFFFFFFFF, 4'b1000};
    v[2]  = '{SUB,  32'h00000005, 32'h00000005, 4'b0000, 32'h00000000, 4'b0110};
    v[3]  = '{LSL,  32'h80000001, 32'h00000001, 4'b0001, 32'h00000002, 4'b0011};
    v[4]  = '{ROR,  32'h12345678, 32'h00000000, 4'b0010, 32'h12345678, 4'b0010};
    v[5]  = '{ADC,  32'hFFFFFFFF, 32'h00000000, 4'b0010, 32'h00000000, 4'b0110};
    v[6]  = '{RSB,  32'h00000003, 32'h0000000A, 4'b0000, 32'h00000007, 4'b0010};
    v[7]  = '{AND_, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0011, 32'hF000F000, 4'b1011};
    v[8]  = '{OR_,  32'h00000000, 32'h00000000, 4'b0000, 32'h00000000, 4'b0100};
    v[9]  = '{XOR_, 32'hFFFF0000, 32'h0F0F0F0F, 4'b0000, 32'hF0F00F0F, 4'b1000};
    v[10] = '{LSR,  32'h00000003, 32'h00000001, 4'b0000, 32'h00000001, 4'b0010};
    v[11] = '{ASR,  32'h80000000, 32'h00000004, 4'b0010, 32'hF8000000, 4'b1000};
    v[12] = '{ROL,  32'h80000001, 32'h00000001, 4'b0000, 32'h00000003, 4'b0010};
    v[13] = '{LSL,  32'h00000001, 32'h00000021, 4'b0000, 32'h00000002, 4'b0000};
    v[14] = '{ROR,  32'h00000001, 32'h00000001, 4'b0000, 32'h80000000, 4'b1010};
    v[15] = '{SUB,  32'h80000000, 32'h00000001, 4'b0000, 32'h7FFFFFFF, 4'b0011};
    for (int i = 0; i < 16; i++) begin
      send(v[i].op, v[i].a, v[i].b, v[i].fl);
      checks++;
      if (out_valid !== 1'b1) begin
        failures++; $display("FAIL vec%0d out_valid: got %b want 1", i, out_valid);
      end
      checks++;
      if (out_result !== v[i].res) begin
        failures++; $display("FAIL vec%0d result: got %h want %h", i, out_result, v[i].res);
      end
      checks++;
      if (out_flags !== v[i].ofl) begin
        failures++; $display("FAIL vec%0d flags: got %b want %b", i, out_flags, v[i].ofl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mul();
    int lat, bn, rn;
    send(MUL, 32'h00010001, 32'h00010001, 4'b0011);
    wait_result(lat, bn, rn);
    checks++; if (lat != 33) begin failures++; $display("FAIL mul latency: got %0d want 33", lat); end
    checks++; if (bn != 32) begin failures++; $display("FAIL mul busy cycles: got %0d want 32", bn); end
    checks++; if (rn != 0) begin failures++; $display("FAIL mul in_ready while busy: got %0d want 0", rn); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mul busy at done: got %b want 0", busy); end
    checks++; if (out_result !== 32'h00020001) begin failures++; $display("FAIL mul result: got %h want 00020001", out_result); end
    checks++; if (out_flags !== 4'b0011) begin failures++; $display("FAIL mul flags: got %b want 0011", out_flags); end
    @(posedge clk); #1;
  endtask

  task automatic test_div();
    vec_t v[4];
    int lat, bn, rn;
    v[0] = '{UDIV, 32'd100, 32'd7, 4'b0000, 32'd14,         4'b0000};
    v[1] = '{UREM, 32'd100, 32'd7, 4'b0000, 32'd2,          4'b0000};
    v[2] = '{UDIV, 32'd9,   32'd0, 4'b0010, 32'hFFFFFFFF,   4'b1011};
    v[3] = '{UREM, 32'd9,   32'd0, 4'b0000, 32'd9,          4'b0001};
    for (int i = 0; i < 4; i++) begin
      send(v[i].op, v[i].a, v[i].b, v[i].fl);
      wait_result(lat, bn, rn);
      checks++;
      if (lat != 33) begin failures++; $display("FAIL div%0d latency: got %0d want 33", i, lat); end
      checks++;
      if (out_result !== v[i].res) begin
        failures++; $display("FAIL div%0d result: got %h want %h", i, out_result, v[i].res);
      end
      checks++;
      if (out_flags !== v[i].ofl) begin
        failures++; $display("FAIL div%0d flags: got %b want %b", i, out_flags, v[i].ofl);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   ops[3];
    logic [W-1:0] as[3], bs[3], exp[3];
    ops = '{ADD, SUB, XOR_};
    as  = '{32'd1, 32'd10, 32'h000000FF};
    bs  = '{32'd2, 32'd3,  32'h0000000F};
    exp = '{32'd3, 32'd7,  32'h000000F0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_oper = ops[i]; in_a = as[i]; in_b = bs[i]; in_flags = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== exp[i]) begin
        failures++; $display("FAIL b2b%0d: got valid=%b res=%h want valid=1 res=%h", i, out_valid, out_result, exp[i]);
      end
      checks++;
      if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d in_ready: got %b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b drain out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(ADD, 32'd2, 32'd3, 4'b0000);
    in_valid = 1'b1; in_oper = SUB; in_a = 32'd9; in_b = 32'd9;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd5 || out_flags !== 4'b0000) begin
        failures++; $display("FAIL hold%0d: got valid=%b res=%h fl=%b want valid=1 res=5 fl=0000", i, out_valid, out_result, out_flags);
      end
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL hold%0d in_ready: got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL hold release: got valid=%b rdy=%b want valid=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    int stale = 0;
    send(MUL, 32'd3, 32'd5, 4'b0000);
    repeat (5) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop busy: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL async reset: got valid=%b rdy=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid || busy) stale++;
      @(posedge clk); #1;
    end
    checks++; if (stale != 0) begin failures++; $display("FAIL stale after reset: got %0d cycles want 0", stale); end
    send(ADD, 32'd4, 32'd4, 4'b0000);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd8) begin
      failures++; $display("FAIL recovery: got valid=%b res=%h want valid=1 res=8", out_valid, out_result);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_ops();
    test_mul();
    test_div();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
